// File: rtl/ct_vfalu_wb_sched_pkg.sv
// Shared definitions for the vector FALU writeback-port scheduler:
// owner codes, pipe latencies, starvation threshold and slot helpers.
package ct_vfalu_wb_sched_pkg;

    // Writeback owner encoding held in each reservation slot
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FADD  = 2'd1,
        OWN_FCNVT = 2'd2,
        OWN_FSPU  = 2'd3
    } owner_e;

    // Grant-to-writeback latencies of the three pipes
    localparam logic [1:0] LAT_FADD  = 2'd3;
    localparam logic [1:0] LAT_FCNVT = 2'd2;
    localparam logic [1:0] LAT_FSPU  = 2'd1;

    // Slot written by a grant of latency L in the next-cycle table
    localparam logic [1:0] SLOT_FADD  = LAT_FADD  - 2'd1;
    localparam logic [1:0] SLOT_FCNVT = LAT_FCNVT - 2'd1;
    localparam logic [1:0] SLOT_FSPU  = LAT_FSPU  - 2'd1;

    // Wait-counter value at which a still-denied requester becomes starved
    localparam logic [1:0] STARVE_THRESH = 2'd3;

    // One reservation-table entry
    typedef struct packed {
        logic   vld;
        owner_e owner;
    } slot_t;

    // Build a valid slot for the given owner
    function automatic slot_t make_slot(input owner_e o);
        slot_t s;
        s.vld   = 1'b1;
        s.owner = o;
        return s;
    endfunction

    // One-hot writeback select {fspu, fcnvt, fadd} for a slot
    function automatic logic [2:0] owner_decode(input slot_t s);
        logic [2:0] v;
        v = 3'b000;
        if (s.vld) begin
            case (s.owner)
                OWN_FADD:  v = 3'b001;
                OWN_FCNVT: v = 3'b010;
                OWN_FSPU:  v = 3'b100;
                default:   v = 3'b000;
            endcase
        end else begin
            v = 3'b000;
        end
        return v;
    endfunction

endpackage

// File: rtl/ct_vfalu_wb_starve.sv
// Per-requester starvation tracker: a saturating count of consecutive
// denied cycles and a sticky starve flag that holds until the next grant.
module ct_vfalu_wb_starve (
    input  logic forever_cpuclk,
    input  logic cpurst_b,
    input  logic rtu_yy_xx_flush,
    input  logic req,
    input  logic gnt,
    output logic starve
);
    import ct_vfalu_wb_sched_pkg::*;

    logic [1:0] cnt_r;
    logic [1:0] cnt_nxt_s;
    logic       starve_r;
    logic       starve_nxt_s;

    // Next wait count and starve flag from this cycle's request/grant
    always_comb begin
        cnt_nxt_s    = 2'd0;
        starve_nxt_s = starve_r;
        if (req && !gnt) begin
            if (cnt_r == STARVE_THRESH) begin
                cnt_nxt_s = cnt_r;
            end else begin
                cnt_nxt_s = cnt_r + 2'd1;
            end
        end else begin
            cnt_nxt_s = 2'd0;
        end
        if (gnt) begin
            starve_nxt_s = 1'b0;
        end else if (req && (cnt_r == STARVE_THRESH)) begin
            starve_nxt_s = 1'b1;
        end else begin
            starve_nxt_s = starve_r;
        end
    end

    // Counter and flag registers; reset and flush both clear them
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            cnt_r    <= 2'd0;
            starve_r <= 1'b0;
        end else if (rtu_yy_xx_flush) begin
            cnt_r    <= 2'd0;
            starve_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            starve_r <= starve_nxt_s;
        end
    end

    assign starve = starve_r;

endmodule

// File: rtl/ct_vfalu_wb_sched.sv
// Writeback-port scheduler for the vector FALU. A 3-entry reservation
// table records which pipe owns the shared result port in each of the
// next three cycles; a grant of latency L claims entry L. Starvation
// trackers for fcnvt and fspu temporarily mask the longer-latency pipes.
module ct_vfalu_wb_sched (
    input  logic forever_cpuclk,
    input  logic cpurst_b,
    input  logic rtu_yy_xx_flush,
    input  logic fadd_req,
    input  logic fcnvt_req,
    input  logic fspu_req,
    output logic fadd_gnt,
    output logic fcnvt_gnt,
    output logic fspu_gnt,
    output logic wb_fadd_vld,
    output logic wb_fcnvt_vld,
    output logic wb_fspu_vld,
    output logic wb_sched_busy
);
    import ct_vfalu_wb_sched_pkg::*;

    slot_t [2:0] tab_r;
    slot_t [2:0] tab_nxt_s;
    logic  [2:0] wb_vld_r;
    logic        busy_r;
    logic        starve_fcnvt_s;
    logic        starve_fspu_s;
    logic        issue_ok_s;
    logic        fadd_gnt_s;
    logic        fcnvt_gnt_s;
    logic        fspu_gnt_s;

    // Grant arbitration: slot availability, starvation masks, flush/reset kill
    always_comb begin
        issue_ok_s  = cpurst_b & ~rtu_yy_xx_flush;
        // fadd targets a slot beyond the table, so it never collides
        fadd_gnt_s  = issue_ok_s & fadd_req & ~starve_fcnvt_s & ~starve_fspu_s;
        fcnvt_gnt_s = issue_ok_s & fcnvt_req & ~tab_r[LAT_FCNVT].vld & ~starve_fspu_s;
        fspu_gnt_s  = issue_ok_s & fspu_req & ~tab_r[LAT_FSPU].vld;
    end

    // Next table: shift toward entry 0 and install this cycle's grants
    always_comb begin
        tab_nxt_s = '0;
        tab_nxt_s[SLOT_FADD]  = fadd_gnt_s  ? make_slot(OWN_FADD)  : slot_t'(3'b000);
        tab_nxt_s[SLOT_FCNVT] = fcnvt_gnt_s ? make_slot(OWN_FCNVT) : tab_r[2];
        tab_nxt_s[SLOT_FSPU]  = fspu_gnt_s  ? make_slot(OWN_FSPU)  : tab_r[1];
    end

    // Table and registered writeback select/busy; reset and flush empty it
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            tab_r    <= '0;
            wb_vld_r <= 3'b000;
            busy_r   <= 1'b0;
        end else if (rtu_yy_xx_flush) begin
            tab_r    <= '0;
            wb_vld_r <= 3'b000;
            busy_r   <= 1'b0;
        end else begin
            tab_r    <= tab_nxt_s;
            wb_vld_r <= owner_decode(tab_nxt_s[0]);
            busy_r   <= tab_nxt_s[0].vld | tab_nxt_s[1].vld | tab_nxt_s[2].vld;
        end
    end

    ct_vfalu_wb_starve u_starve_fcnvt (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .rtu_yy_xx_flush(rtu_yy_xx_flush),
        .req            (fcnvt_req),
        .gnt            (fcnvt_gnt_s),
        .starve         (starve_fcnvt_s)
    );

    ct_vfalu_wb_starve u_starve_fspu (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .rtu_yy_xx_flush(rtu_yy_xx_flush),
        .req            (fspu_req),
        .gnt            (fspu_gnt_s),
        .starve         (starve_fspu_s)
    );

    assign fadd_gnt      = fadd_gnt_s;
    assign fcnvt_gnt     = fcnvt_gnt_s;
    assign fspu_gnt      = fspu_gnt_s;
    assign wb_fadd_vld   = wb_vld_r[0];
    assign wb_fcnvt_vld  = wb_vld_r[1];
    assign wb_fspu_vld   = wb_vld_r[2];
    assign wb_sched_busy = busy_r;

endmodule

// File: tb/tb_ct_vfalu_wb_sched.sv
// Bench for ct_vfalu_wb_sched: per-cycle vector table of inputs and
// expected grants, plus a scoreboard of pending writebacks derived from
// the expected grants and their pipe latencies.
module tb_ct_vfalu_wb_sched;

    logic forever_cpuclk = 1'b0;
    logic cpurst_b = 1'b0;
    logic rtu_yy_xx_flush = 1'b0;
    logic fadd_req = 1'b0;
    logic fcnvt_req = 1'b0;
    logic fspu_req = 1'b0;
    logic fadd_gnt, fcnvt_gnt, fspu_gnt;
    logic wb_fadd_vld, wb_fcnvt_vld, wb_fspu_vld, wb_sched_busy;

    ct_vfalu_wb_sched dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .rtu_yy_xx_flush(rtu_yy_xx_flush),
        .fadd_req       (fadd_req),
        .fcnvt_req      (fcnvt_req),
        .fspu_req       (fspu_req),
        .fadd_gnt       (fadd_gnt),
        .fcnvt_gnt      (fcnvt_gnt),
        .fspu_gnt       (fspu_gnt),
        .wb_fadd_vld    (wb_fadd_vld),
        .wb_fcnvt_vld   (wb_fcnvt_vld),
        .wb_fspu_vld    (wb_fspu_vld),
        .wb_sched_busy  (wb_sched_busy)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    // One cycle of stimulus; gnt bits are {fspu, fcnvt, fadd}
    typedef struct {
        logic       rst_b;
        logic       flush;
        logic       fa;
        logic       fc;
        logic       fs;
        logic [2:0] gnt;
    } vec_t;

    // Pending writeback: cycle it is due and one-hot owner {fspu, fcnvt, fadd}
    typedef struct {
        int         due;
        logic [2:0] own;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic void add_vec(input logic r, input logic fl, input logic a,
                                    input logic c, input logic s, input logic [2:0] g);
        vec_t v;
        v.rst_b = r;
        v.flush = fl;
        v.fa    = a;
        v.fc    = c;
        v.fs    = s;
        v.gnt   = g;
        vecs.push_back(v);
    endfunction

    function automatic void add_idle(input int n);
        for (int i = 0; i < n; i++) begin
            add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        end
    endfunction

    function automatic void sb_push(input int due, input logic [2:0] own);
        sb_t e;
        e.due = due;
        e.own = own;
        sb.push_back(e);
    endfunction

    task automatic run_cycle(input logic r, input logic fl, input logic a,
                             input logic c, input logic s, input logic [2:0] eg);
        logic [2:0] got_g;
        logic [2:0] got_wb;
        logic [2:0] exp_wb;
        logic       exp_busy;
        sb_t        keep[$];
        @(negedge forever_cpuclk);
        cpurst_b        = r;
        rtu_yy_xx_flush = fl;
        fadd_req        = a;
        fcnvt_req       = c;
        fspu_req        = s;
        #1;
        exp_wb   = 3'b000;
        exp_busy = 1'b0;
        foreach (sb[i]) begin
            if (sb[i].due == cyc) exp_wb = exp_wb | sb[i].own;
            if (sb[i].due >= cyc) exp_busy = 1'b1;
        end
        got_g  = {fspu_gnt, fcnvt_gnt, fadd_gnt};
        got_wb = {wb_fspu_vld, wb_fcnvt_vld, wb_fadd_vld};
        n_checks++;
        if (got_g !== eg) begin
            n_errors++;
            $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, got_g, eg);
        end
        n_checks++;
        if (got_wb !== exp_wb) begin
            n_errors++;
            $display("FAIL wb_vld cyc=%0d got=%b exp=%b", cyc, got_wb, exp_wb);
        end
        n_checks++;
        if (wb_sched_busy !== exp_busy) begin
            n_errors++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, wb_sched_busy, exp_busy);
        end
        // Retire due entries; reset or flush discards everything pending
        foreach (sb[i]) begin
            if ((sb[i].due > cyc) && r && !fl) keep.push_back(sb[i]);
        end
        sb = keep;
        if (r && !fl) begin
            if (eg[0]) sb_push(cyc + 3, 3'b001);
            if (eg[1]) sb_push(cyc + 2, 3'b010);
            if (eg[2]) sb_push(cyc + 1, 3'b100);
        end
        cyc++;
    endtask

    initial begin
        // Reset with requests high: grants stay low, outputs cleared
        add_vec(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000);
        add_vec(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000);
        // fadd alone for 4 cycles, writebacks 3 cycles later
        for (int i = 0; i < 4; i++) add_vec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001);
        add_idle(4);
        // fcnvt blocked by fadd's slot, then granted once it is free
        add_vec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001);
        add_vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
        add_vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010);
        add_idle(3);
        // fadd vs fcnvt continuous: fcnvt starves, fadd masked until fcnvt wins
        add_vec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b011);
        for (int i = 0; i < 4; i++) add_vec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b001);
        add_vec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
        add_vec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010);
        add_vec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b011);
        add_idle(3);
        // fcnvt vs fspu continuous: fspu starves, fcnvt masked until fspu wins
        add_vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b110);
        for (int i = 0; i < 4; i++) add_vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b010);
        add_vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
        add_vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b100);
        add_vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b110);
        add_idle(3);
        // All three from an empty table: fspu, fcnvt, fadd on consecutive cycles
        add_vec(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b111);
        add_idle(3);

        cpurst_b = 1'b0;
        repeat (2) @(negedge forever_cpuclk);

        foreach (vecs[i]) begin
            run_cycle(vecs[i].rst_b, vecs[i].flush, vecs[i].fa, vecs[i].fc,
                      vecs[i].fs, vecs[i].gnt);
        end

        // Flush right after fadd+fcnvt grants: no grants, nothing written back
        run_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b011);
        run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

        // Reset with all three entries valid, then a fresh fcnvt grant
        run_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b111);
        run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001);
        run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
